// File: rtl/clk_mon_if.sv
// Monitor bus: the monitored clock going in and the lock/measurement results
// coming out. master = stimulus/observer side, slave = clk_mon.
interface clk_mon_if #(
   parameter int CW = 16
);
   logic          clk_in;
   logic          locked;
   logic [CW-1:0] period;
   logic          period_vld;
   logic          err;
   logic [1:0]    state;

   modport master (
      output clk_in,
      input  locked, period, period_vld, err, state
   );

   modport slave (
      input  clk_in,
      output locked, period, period_vld, err, state
   );
endinterface

// File: rtl/clk_mon.sv
// Clock monitor: measures the period of an asynchronous clk_in in clk cycles,
// qualifies lock with hysteresis and flags bad periods or a missing clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// UNLK  | no reference edge yet; the next rise only arms the measurement
// ACQ   | measuring; counting consecutive good periods toward lock
// LOCK  | locked; counting consecutive bad periods toward unlock
module clk_mon #(
   parameter int EXP_CYC    = 27,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_CNT = 2,
   parameter int TIMEOUT    = 64,
   parameter int CW         = 16
) (
   input logic        clk,
   input logic        rst,
   clk_mon_if.slave   mon
);

   typedef enum logic [1:0] {
      UNLK = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam int GW   = $clog2(LOCK_CNT + 1);
   localparam int BW   = $clog2(UNLOCK_CNT + 1);
   // Lower bound clamps at zero so a wide tolerance cannot wrap.
   localparam int LO_I = (TOL >= EXP_CYC) ? 0 : (EXP_CYC - TOL);

   localparam logic [CW-1:0] LO_V   = CW'(LO_I);
   localparam logic [CW-1:0] HI_V   = CW'(EXP_CYC + TOL);
   localparam logic [CW-1:0] TO_V   = CW'(TIMEOUT);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
   localparam logic [BW-1:0] ULCK_V = BW'(UNLOCK_CNT);

   logic          sync1, sync2, prev;
   logic [CW-1:0] cnt, cnt_d;
   state_t        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [BW-1:0] bad_q, bad_d;
   logic [CW-1:0] period_q, period_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;
   logic          locked_q;
   logic          rise, good, timeout;

   assign rise    = sync2 & ~prev;
   assign good    = (cnt >= LO_V) && (cnt <= HI_V);
   // A rise landing on the saturation cycle wins over the timeout.
   assign timeout = (cnt == TO_V) && !rise;

   // Free-running period counter: restarts at 1 on each rise, sticks at TIMEOUT.
   always_comb begin
      cnt_d = cnt;
      if (rise)
         cnt_d = CW'(1);
      else if (cnt != TO_V)
         cnt_d = cnt + CW'(1);
   end

   // Next-state, hysteresis counters and result pulses.
   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      bad_d    = bad_q;
      period_d = period_q;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         UNLK: begin
            if (rise)
               state_d = ACQ;
         end
         ACQ: begin
            if (rise) begin
               period_d = cnt;
               vld_d    = 1'b1;
               if (good) begin
                  if (good_q + GW'(1) == LOCK_V) begin
                     state_d = LOCK;
                     good_d  = '0;
                  end else begin
                     good_d  = good_q + GW'(1);
                  end
               end else begin
                  good_d = '0;
                  err_d  = 1'b1;
               end
            end else if (timeout) begin
               state_d = UNLK;
               good_d  = '0;
               bad_d   = '0;
               err_d   = 1'b1;
            end
         end
         LOCK: begin
            if (rise) begin
               period_d = cnt;
               vld_d    = 1'b1;
               if (good) begin
                  bad_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (bad_q + BW'(1) == ULCK_V) begin
                     state_d = ACQ;
                     bad_d   = '0;
                  end else begin
                     bad_d   = bad_q + BW'(1);
                  end
               end
            end else if (timeout) begin
               state_d = UNLK;
               good_d  = '0;
               bad_d   = '0;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = UNLK;
            good_d  = '0;
            bad_d   = '0;
         end
      endcase
   end

   // Synchronizer, edge register and all state; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         prev     <= 1'b0;
         cnt      <= '0;
         state_q  <= UNLK;
         good_q   <= '0;
         bad_q    <= '0;
         period_q <= '0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         sync1    <= mon.clk_in;
         sync2    <= sync1;
         prev     <= sync2;
         cnt      <= cnt_d;
         state_q  <= state_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         period_q <= period_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
         locked_q <= (state_d == LOCK);
      end
   end

   assign mon.locked     = locked_q;
   assign mon.period     = period_q;
   assign mon.period_vld = vld_q;
   assign mon.err        = err_q;
   assign mon.state      = state_q;

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: drives clk_in as whole periods of chosen length and
// compares every output every cycle against an event-level reference model.
module tb_clk_mon;

   localparam int EXP_CYC    = 27;
   localparam int TOL        = 1;
   localparam int LOCK_CNT   = 8;
   localparam int UNLOCK_CNT = 2;
   localparam int TIMEOUT    = 64;
   localparam int CW         = 16;
   localparam int LO         = (TOL >= EXP_CYC) ? 0 : EXP_CYC - TOL;
   localparam int HI         = EXP_CYC + TOL;

   logic clk = 1'b0;
   logic rst = 1'b1;

   clk_mon_if #(.CW(CW)) mon_bus ();

   clk_mon #(
      .EXP_CYC(EXP_CYC), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
      .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT), .CW(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (mon_bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: clk_in history, cycles since last accepted rise, state
   logic d0, d1, d2, d3;
   int   m_st, m_since, m_gc, m_bc, m_per;
   logic m_vld, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input logic v, input logic r);
      logic rise, g;
      m_vld = 1'b0;
      m_err = 1'b0;
      if (r) begin
         {d0, d1, d2, d3} = 4'b0;
         m_st = 0; m_since = 0; m_gc = 0; m_bc = 0; m_per = 0;
         return;
      end
      d3 = d2; d2 = d1; d1 = d0; d0 = v;
      // an edge driven before edge n is seen by the monitor at edge n+2
      rise = d2 & ~d3;
      if (rise) begin
         if (m_st != 0) begin
            m_per = m_since;
            m_vld = 1'b1;
            g = (m_per >= LO) && (m_per <= HI);
            if (m_st == 1) begin
               if (g) begin
                  m_gc++;
                  if (m_gc == LOCK_CNT) begin m_st = 2; m_gc = 0; end
               end else begin
                  m_gc = 0; m_err = 1'b1;
               end
            end else begin
               if (g) m_bc = 0;
               else begin
                  m_bc++; m_err = 1'b1;
                  if (m_bc == UNLOCK_CNT) begin m_st = 1; m_bc = 0; end
               end
            end
         end else begin
            m_st = 1;
         end
         m_since = 1;
      end else begin
         if (m_since == TIMEOUT && m_st != 0) begin
            m_st = 0; m_gc = 0; m_bc = 0; m_err = 1'b1;
         end
         if (m_since < TIMEOUT) m_since++;
      end
   endtask

   task automatic tick(input logic v, input logic r);
      mon_bus.clk_in = v;
      rst = r;
      @(posedge clk);
      #1;
      model_step(v, r);
      chk("state",      32'(mon_bus.state),      32'(m_st));
      chk("locked",     32'(mon_bus.locked),     32'(m_st == 2));
      chk("period",     32'(mon_bus.period),     32'(m_per));
      chk("period_vld", 32'(mon_bus.period_vld), 32'(m_vld));
      chk("err",        32'(mon_bus.err),        32'(m_err));
   endtask

   task automatic per(input int k);
      for (int i = 0; i < k; i++) tick(i < k / 2 ? 1'b1 : 1'b0, 1'b0);
   endtask

   task automatic pers(input int k, input int n);
      for (int i = 0; i < n; i++) per(k);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic do_reset;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      idle(3);
   endtask

   initial begin
      mon_bus.clk_in = 1'b0;
      do_reset();

      // nominal lock: arming edge + 8 good periods
      pers(27, 11);
      chk("lock_nominal", 32'(mon_bus.locked), 32'd1);

      // single bad then good keeps lock, two bad drop to ACQ
      per(30); per(27);
      per(30); per(30); per(30);
      chk("unlock_bad", 32'(mon_bus.state), 32'd1);

      // persistent 30: stays in ACQ, err every period
      pers(30, 5);

      // tolerance edges 26/28 relock, then 25 is bad
      for (int i = 0; i < 10; i++) per(i % 2 == 0 ? 26 : 28);
      per(25);
      pers(27, 3);

      // missing clock from LOCK
      pers(27, 9);
      idle(80);
      chk("timeout_state", 32'(mon_bus.state), 32'd0);
      chk("timeout_period", 32'(mon_bus.period), 32'd27);

      // rise exactly at saturation vs one cycle late
      pers(27, 3);
      per(64); per(27); per(65); pers(27, 3);

      // reset while locked, then relock
      pers(27, 10);
      do_reset();
      chk("rst_period", 32'(mon_bus.period), 32'd0);
      pers(27, 10);

      // randomized periods
      for (int i = 0; i < 120; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 11)      per(int'($urandom_range(26, 28)));
         else if (r < 16) per(int'($urandom_range(20, 35)));
         else if (r < 18) per(int'($urandom_range(2, 10)));
         else if (r < 19) per(int'($urandom_range(60, 70)));
         else if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(40, 90)));
         else do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
